// File: rtl/eth_pkt_sync_fifo.sv
// eth_pkt_sync_fifo
//   Single-clock packet FIFO between the RX MAC/CRC checker and frame
//   consumers. Words of a frame become readable only once the frame is
//   committed by its last word; a dropped or overflowed frame is rolled back
//   so it never reaches the read side. Output is first-word-fall-through.
//
// Ports
//   clk, rst_n               clock, async active-low reset
//   wr_data/wr_en/wr_last    write word, strobe, end-of-frame marker
//   wr_drop                  discard the uncommitted frame
//   wr_full/almost_full      working level == depth / >= af_th
//   wr_level, af_th          working level (incl. uncommitted), threshold
//   rd_data/rd_last/rd_valid head word (FWFT)
//   rd_en, rd_empty          pop strobe, ~rd_valid
//   almost_empty, rd_level   committed level <= ae_th, committed level
//   ae_th                    almost-empty threshold
//   pkt_cnt, drop_cnt        frames committed-not-popped, frames discarded
//   overflow, underflow      sticky error flags
module eth_pkt_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11,
  parameter int PKT_MODE   = 1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic                  wr_last,
  input  logic                  wr_drop,
  output logic                  wr_full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  input  logic [ADDR_WIDTH:0]   af_th,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_en,
  output logic                  rd_empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  input  logic [ADDR_WIDTH:0]   ae_th,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam bit P_PKT = (PKT_MODE != 0);
  localparam logic [PW-1:0]        P_ONE   = 1;
  localparam logic [CNT_WIDTH-1:0] C_ONE   = 1;
  localparam logic [CNT_WIDTH-1:0] C_MAX   = '1;
  localparam logic [PW-1:0]        P_DEPTH = PW'(DEPTH);

  logic [DATA_WIDTH:0]   r_mem [DEPTH];
  logic [DATA_WIDTH:0]   r_ram_q;       // RAM registered read port
  logic                  r_ram_v;       // r_ram_q holds an unconsumed word
  logic [PW-1:0]         r_wptr, r_cptr, r_rptr, r_fptr;
  logic                  r_bad;         // current frame lost a word to overflow
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_last, r_rd_valid;
  logic [CNT_WIDTH-1:0]  r_pkt_cnt, r_drop_cnt;
  logic                  r_ovf, r_udf;

  logic [PW-1:0] w_wr_level, w_rd_level;
  logic w_full, w_drop_req, w_wr_acc, w_ovf, w_bad_end, w_drop_evt;
  logic w_commit, w_pkt_inc, w_pkt_dec, w_pop, w_move, w_fetch;

  assign w_wr_level = r_wptr - r_rptr;
  assign w_rd_level = r_cptr - r_rptr;
  assign w_full     = (w_wr_level == P_DEPTH);

  assign w_drop_req = P_PKT & wr_drop;
  assign w_wr_acc   = wr_en & ~w_full & ~w_drop_req;
  assign w_ovf      = wr_en & w_full & ~w_drop_req;
  // End of a frame that already lost words (or loses this one): roll back.
  assign w_bad_end  = P_PKT & wr_en & wr_last & ~w_drop_req & (r_bad | w_ovf);
  assign w_drop_evt = (w_drop_req & (r_wptr != r_cptr)) | w_bad_end;
  assign w_commit   = w_wr_acc & (~P_PKT | (wr_last & ~r_bad));
  assign w_pkt_inc  = w_wr_acc & wr_last & (~P_PKT | ~r_bad);

  // Two-stage read: RAM register, then output register. The RAM stage only
  // reloads when its word moves on, so pops stream one per cycle.
  assign w_pop     = rd_en & r_rd_valid;
  assign w_pkt_dec = w_pop & r_rd_last;
  assign w_move    = r_ram_v & (~r_rd_valid | w_pop);
  assign w_fetch   = (r_cptr != r_fptr) & (~r_ram_v | w_move);

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr[ADDR_WIDTH-1:0]] <= {wr_last, wr_data};
    if (w_fetch)  r_ram_q <= r_mem[r_fptr[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_cptr     <= '0;
      r_rptr     <= '0;
      r_fptr     <= '0;
      r_bad      <= 1'b0;
      r_ram_v    <= 1'b0;
      r_rd_data  <= '0;
      r_rd_last  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
    end else begin
      if (w_drop_evt)    r_wptr <= r_cptr;
      else if (w_wr_acc) r_wptr <= r_wptr + P_ONE;

      if (w_drop_req | w_bad_end) r_bad <= 1'b0;
      else if (P_PKT & w_ovf)     r_bad <= 1'b1;

      if (w_commit) r_cptr <= r_wptr + P_ONE;

      if (w_drop_evt && r_drop_cnt != C_MAX) r_drop_cnt <= r_drop_cnt + C_ONE;

      if (w_pkt_inc && !w_pkt_dec && r_pkt_cnt != C_MAX)
        r_pkt_cnt <= r_pkt_cnt + C_ONE;
      else if (w_pkt_dec && !w_pkt_inc && r_pkt_cnt != '0)
        r_pkt_cnt <= r_pkt_cnt - C_ONE;

      if (w_fetch) r_fptr <= r_fptr + P_ONE;
      r_ram_v <= w_fetch | (r_ram_v & ~w_move);

      if (w_move) begin
        r_rd_data  <= r_ram_q[DATA_WIDTH-1:0];
        r_rd_last  <= r_ram_q[DATA_WIDTH];
        r_rd_valid <= 1'b1;
      end else if (w_pop) begin
        r_rd_valid <= 1'b0;
      end

      if (w_pop) r_rptr <= r_rptr + P_ONE;

      if (w_ovf)               r_ovf <= 1'b1;
      if (rd_en & ~r_rd_valid) r_udf <= 1'b1;
    end
  end

  assign wr_full      = w_full;
  assign wr_level     = w_wr_level;
  assign rd_level     = w_rd_level;
  assign almost_full  = (w_wr_level >= af_th);
  assign almost_empty = (w_rd_level <= ae_th);
  assign rd_data      = r_rd_data;
  assign rd_last      = r_rd_last;
  assign rd_valid     = r_rd_valid;
  assign rd_empty     = ~r_rd_valid;
  assign pkt_cnt      = r_pkt_cnt;
  assign drop_cnt     = r_drop_cnt;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;
endmodule
